// File: rtl/sensor_sample_driver.sv
// sensor_sample_driver
// Producer side of the sensor sample interface. Samples arrive through a
// valid/ready handshake into a small FIFO. Each sample is then presented on
// new_data and framed by a strobe on state: the data is set up first, then
// state is high, then state is low. The downstream sensor captures on the
// rising edge of state.
module sensor_sample_driver #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 5,
  parameter int LOW_CYC   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           new_data,
  output logic                       state,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [7:0]                 sent_count
);

  // ------------------------------------------------------------------
  // Derived sizes
  // ------------------------------------------------------------------
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int MAX_AB  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int MAX_CYC = (MAX_AB > LOW_CYC) ? MAX_AB : LOW_CYC;
  // The timer only ever holds values up to MAX_CYC-1.
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_HIGH  = TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LOW   = TMR_W'(LOW_CYC - 1);

  // Frame sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  // ------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] head_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Full/empty come straight from the count register, so in_ready never
  // depends combinationally on in_valid or on a same-cycle pop.
  assign fifo_full  = (count_reg == CNT_W'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push       = in_valid && !fifo_full;
  assign head_data  = slot_q[rd_ptr_reg];

  // One register per FIFO slot; each slot loads only when the write
  // pointer addresses it during an accepted push.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_reg;
      logic             wr_sel;

      assign wr_sel     = push && (wr_ptr_reg == PTR_W'(gi));
      assign slot_q[gi] = slot_reg;

      // Capture the incoming sample into this slot.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          slot_reg <= '0;
        end else if (wr_sel) begin
          slot_reg <= in_data;
        end
      end
    end
  endgenerate

  // Next pointer/occupancy values; a push and pop together leave the
  // count unchanged.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // ------------------------------------------------------------------
  // Frame sequencer
  // ------------------------------------------------------------------
  logic [1:0]       fsm_reg,    fsm_next;
  logic [TMR_W-1:0] tmr_reg,    tmr_next;
  logic [WIDTH-1:0] data_reg,   data_next;
  logic             strobe_reg, strobe_next;
  logic [7:0]       sent_reg,   sent_next;
  logic             tmr_done;

  assign tmr_done = (tmr_reg == '0);

  // Frame sequencing: new_data is only loaded at a pop, which happens
  // only in IDLE or at the very end of LOW, so it can never change while
  // the strobe is high. enable is looked at only at those two points.
  always_comb begin
    fsm_next    = fsm_reg;
    tmr_next    = tmr_reg;
    data_next   = data_reg;
    strobe_next = strobe_reg;
    sent_next   = sent_reg;
    pop         = 1'b0;
    case (fsm_reg)
      ST_IDLE: begin
        strobe_next = 1'b0;
        if (enable && !fifo_empty) begin
          pop       = 1'b1;
          data_next = head_data;
          tmr_next  = TMR_SETUP;
          fsm_next  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        strobe_next = 1'b0;
        if (tmr_done) begin
          strobe_next = 1'b1;
          tmr_next    = TMR_HIGH;
          sent_next   = sent_reg + 8'd1;
          fsm_next    = ST_HIGH;
        end else begin
          tmr_next = tmr_reg - TMR_W'(1);
        end
      end
      ST_HIGH: begin
        if (tmr_done) begin
          strobe_next = 1'b0;
          tmr_next    = TMR_LOW;
          fsm_next    = ST_LOW;
        end else begin
          tmr_next = tmr_reg - TMR_W'(1);
        end
      end
      ST_LOW: begin
        strobe_next = 1'b0;
        if (tmr_done) begin
          // Chain straight into the next frame when possible so that
          // back-to-back frames have no idle gap.
          if (enable && !fifo_empty) begin
            pop       = 1'b1;
            data_next = head_data;
            tmr_next  = TMR_SETUP;
            fsm_next  = ST_SETUP;
          end else begin
            fsm_next = ST_IDLE;
          end
        end else begin
          tmr_next = tmr_reg - TMR_W'(1);
        end
      end
      default: begin
        strobe_next = 1'b0;
        fsm_next    = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, timer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_reg    <= ST_IDLE;
      tmr_reg    <= '0;
      data_reg   <= '0;
      strobe_reg <= 1'b0;
      sent_reg   <= '0;
    end else begin
      fsm_reg    <= fsm_next;
      tmr_reg    <= tmr_next;
      data_reg   <= data_next;
      strobe_reg <= strobe_next;
      sent_reg   <= sent_next;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign in_ready   = !fifo_full;
  assign new_data   = data_reg;
  assign state      = strobe_reg;
  assign busy       = (fsm_reg != ST_IDLE);
  assign fifo_count = count_reg;
  assign sent_count = sent_reg;

endmodule
